// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the interrupt controller: data width, FSM states and register offsets.
package irq_ctl_pkg;

  localparam int unsigned IRQ_DATA_W = 16;
  localparam int unsigned IRQ_ID_W   = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_e;

  localparam int unsigned IRQ_MASK_OFS = 0;
  localparam int unsigned IRQ_PEND_OFS = 1;
  localparam int unsigned IRQ_STAT_OFS = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder: reports the smallest set bit of i_req.
module irq_prio_enc
  import irq_ctl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0]     i_req,
  output logic [IRQ_ID_W-1:0] o_id,
  output logic                o_valid
);

  logic [NSRC-1:0] w_shift;

  // Scan from the top down so the lowest set index is the last one assigned.
  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    w_shift = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      w_shift = i_req >> (i - 1);
      if (w_shift[0]) begin
        o_id    = IRQ_ID_W'(i - 1);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt request controller with bus-snooped MASK/PEND/STAT registers and req/ack/ret handshake.
// Define IRQ_CTL_EDGE_EN for rising-edge source capture; level capture otherwise.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int unsigned             NSRC       = 8,
  parameter int unsigned             DATA_W     = IRQ_DATA_W,
  parameter logic [DATA_W-1:0]       BASE_ADDR  = 16'hFFF0,
  parameter logic [DATA_W-1:0]       VEC_BASE   = 16'h0010,
  parameter int unsigned             VEC_STRIDE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              bus_wen,
  input  logic [DATA_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              irq_req,
  output logic [DATA_W-1:0] irq_vec,
  input  logic              irq_ack,
  input  logic              irq_ret
);

  localparam logic [DATA_W-1:0] A_MASK = DATA_W'(BASE_ADDR + IRQ_MASK_OFS);
  localparam logic [DATA_W-1:0] A_PEND = DATA_W'(BASE_ADDR + IRQ_PEND_OFS);
  localparam logic [DATA_W-1:0] A_STAT = DATA_W'(BASE_ADDR + IRQ_STAT_OFS);

  irq_state_e            r_state;
  logic [NSRC-1:0]       r_mask;
  logic [NSRC-1:0]       r_pend;
  logic [IRQ_ID_W-1:0]   r_cur_id;
  logic                  r_req;
  logic [DATA_W-1:0]     r_vec;

  logic                  w_sel_mask, w_sel_pend, w_sel_stat;
  logic                  w_busy, w_ack_ok, w_withdraw;
  logic [NSRC-1:0]       w_set, w_clr, w_cur_bit, w_eligible;
  logic [IRQ_ID_W-1:0]   w_sel_id;
  logic                  w_sel_valid;
  logic [DATA_W-1:0]     w_vec;
  logic                  w_unused;

  assign w_sel_mask = (bus_addr == A_MASK);
  assign w_sel_pend = (bus_addr == A_PEND);
  assign w_sel_stat = (bus_addr == A_STAT);
  assign w_busy     = (r_state == IRQ_SVC);
  assign w_cur_bit  = NSRC'(1) << r_cur_id;
  assign w_ack_ok   = (r_state == IRQ_REQ) && irq_ack;
  assign w_withdraw = ((r_mask & w_cur_bit) == '0) || ((r_pend & w_cur_bit) == '0);
  assign w_eligible = r_pend & r_mask;
  assign w_vec      = VEC_BASE + DATA_W'(w_sel_id) * DATA_W'(VEC_STRIDE);
  assign w_unused   = &{1'b0, bus_wdata};

`ifdef IRQ_CTL_EDGE_EN
  logic [NSRC-1:0] r_src_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_src_d <= '0;
    else          r_src_d <= irq_src;
  end

  assign w_set = irq_src & ~r_src_d;
`else
  assign w_set = irq_src;
`endif

  always_comb begin
    w_clr = (bus_wen && w_sel_pend) ? bus_wdata[NSRC-1:0] : '0;
    if (w_ack_ok) w_clr = w_clr | w_cur_bit;
  end

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .i_req   (w_eligible),
    .o_id    (w_sel_id),
    .o_valid (w_sel_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | w_set) & ~w_clr;
      if (bus_wen && w_sel_mask) r_mask <= bus_wdata[NSRC-1:0];
    end
  end

  // Ack takes priority over a same-cycle withdraw; SVC blocks nesting until ret.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IRQ_IDLE;
      r_cur_id <= '0;
      r_req    <= 1'b0;
      r_vec    <= '0;
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_sel_valid) begin
            r_cur_id <= w_sel_id;
            r_vec    <= w_vec;
            r_req    <= 1'b1;
            r_state  <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            r_req   <= 1'b0;
            r_state <= IRQ_SVC;
          end else if (w_withdraw) begin
            r_req   <= 1'b0;
            r_state <= IRQ_IDLE;
          end
        end
        IRQ_SVC: begin
          if (irq_ret) r_state <= IRQ_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IRQ_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (w_sel_mask)      bus_rdata[NSRC-1:0] = r_mask;
    else if (w_sel_pend) bus_rdata[NSRC-1:0] = r_pend;
    else if (w_sel_stat) bus_rdata[7:0]      = {w_busy, 3'b000, r_cur_id};
  end

  assign irq_req = r_req;
  assign irq_vec = r_vec;

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Interrupt/exception request controller that sits directly upstream of the asca16core and drives its interrupt request/vector inputs.
- Collects up to NSRC external interrupt sources into a pending register and gates them with a software-writable mask.
- Selects the lowest-numbered pending, unmasked source and hands its vector to the core with a req/ack/ret handshake.
- Mask/pending/status registers are memory-mapped by snooping the core's RAM-side bus (wen/addr/data).

Parameters:
NSRC, 8, number of interrupt sources (1..16)
DATA_W, 16, data/address width; matches `DATA_W from the shared defines
BASE_ADDR, 16'hFFF0, address of MASK register; PEND at BASE_ADDR+1, STAT at BASE_ADDR+2
VEC_BASE, 16'h0010, vector address of source 0
VEC_STRIDE, 2, address distance between consecutive vectors

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
irq_src  input  NSRC  interrupt sources, active-high, already synchronous to clk
bus_wen  input  1  core bus write strobe (1 = write)
bus_addr  input  DATA_W  core bus address
bus_wdata  input  DATA_W  core bus write data
bus_rdata  output  DATA_W  register read data, combinational from bus_addr
irq_req  output  1  interrupt request to core
irq_vec  output  DATA_W  vector address, valid while irq_req=1
irq_ack  input  1  core accepts request (one-cycle pulse)
irq_ret  input  1  core executed return-from-interrupt (one-cycle pulse)

Behaviour:
- Reset (reset_n=0, async): mask=0, pend=0, cur_id=0, state=IDLE, irq_req=0, irq_vec=0. bus_rdata follows the register values, so it reads 0 at the register addresses.
- Pending capture, level mode (default): each cycle pend <= (pend | irq_src) & ~clr, where clr = W1C write bits | ack-clear bit. A source still high re-sets its bit on the next cycle.
- Register writes take effect on the clock edge where bus_wen=1 and the address matches:
  - MASK: mask <= bus_wdata[NSRC-1:0].
  - PEND: write-1-to-clear.
  - STAT: read-only; writes are ignored.
- Register reads: bus_rdata is zero-extended.
  - MASK -> mask; PEND -> pend; STAT -> {busy, 3'b0, cur_id[3:0]} placed in bits [7:0].
  - Any other address -> 0.
- Selection: eligible = pend & mask. sel_id = lowest set index of eligible.
- FSM:
  - IDLE: if eligible != 0, then cur_id <= sel_id, irq_vec <= VEC_BASE + sel_id*VEC_STRIDE, irq_req <= 1, go to REQ. Latency is 1 cycle from pend&mask becoming nonzero to irq_req=1.
  - REQ: irq_req stays 1 and irq_vec stays stable.
    - On irq_ack: clear pend[cur_id], irq_req <= 0, go to SVC.
    - If mask[cur_id] or pend[cur_id] becomes 0 (SW withdraw) with no ack that cycle: irq_req <= 0, go to IDLE.
    - If ack and withdraw happen in the same cycle, ack wins.
  - SVC: busy=1, irq_req=0. No new request is issued (no nesting). On irq_ret go to IDLE. Pending sources arriving meanwhile are held and issued from IDLE on the cycle after.
- irq_ack outside REQ and irq_ret outside SVC are ignored.
- Source bits at index >= NSRC do not exist; the corresponding mask/pend bits read 0.
- vector arithmetic is modulo 2^DATA_W; wrap is permitted and not flagged.
- Reset asserted mid-handshake returns the block to IDLE immediately, with irq_req=0.

Optional Feature:
- IRQ_CTL_EDGE_EN defined: each source goes through a rising-edge detector (one flop per source, reset 0). pend sets only on a 0->1 transition of irq_src. A held-high source produces exactly one request.
- Undefined: level-sensitive capture as above, and the edge flops are absent.

Decomposition:
- Shared package/def header holds DATA_W (existing `DATA_W), the FSM state encodings (IRQ_IDLE=2'd0, IRQ_REQ=2'd1, IRQ_SVC=2'd2), and the register offsets (IRQ_MASK_OFS=0, IRQ_PEND_OFS=1, IRQ_STAT_OFS=2).
- One natural sub-module: irq_prio_enc, a parameterized lowest-index priority encoder (NSRC in; id and valid out), purely combinational.

Test Plan:
- Reset, then read BASE_ADDR..+2 -> all 0. Then irq_src=8'h01 with mask=0 -> PEND reads 1 and irq_req stays 0.
- Write MASK=8'h0C, drive irq_src=8'h0C -> irq_req=1 one cycle later, irq_vec=16'h0014 (id 2). Ack -> SVC with STAT=8'h82. irq_ret -> IDLE; next cycle irq_vec=16'h0016 (id 3).
- In REQ for id 2, write MASK=0 -> irq_req drops next edge, FSM returns to IDLE, no ack is needed.
- Same cycle: irq_ack=1 and mask[cur_id] cleared -> FSM enters SVC and pend[cur_id]=0.
- Level mode: hold irq_src[0]=1 through ack and ret -> a second request with vec 16'h0010. With IRQ_CTL_EDGE_EN -> no second request.
- Assert reset_n=0 while in SVC -> irq_req=0 and STAT=0 asynchronously. After release, a pending source re-requests from IDLE.
